// File: rtl/imem_loader_pkg.sv
// Shared configuration for the instruction-memory loader: depth, address width,
// length field width and FSM state encoding.
package imem_loader_pkg;

   localparam int IMEM_DEPTH  = 64;
   localparam int IMEM_ADDR_W = $clog2(IMEM_DEPTH);
   localparam int LEN_W       = 16;

   typedef logic [LEN_W-1:0] len_t;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LEN_LO = 3'd1;
   localparam logic [2:0] S_LEN_HI = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_CSUM   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_ERR    = 3'd6;

   // A frame is loadable only if it carries at least one word and fits in memory.
   function automatic logic len_ok(input len_t n, input int depth);
      return (n != '0) && (int'(n) <= depth);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
   parameter int ADDR_W = 6
);
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;

   modport master (
      output byte_valid, byte_data,
      input  byte_ready, we, waddr, wdata
   );

   modport slave (
      input  byte_valid, byte_data,
      output byte_ready, we, waddr, wdata
   );
endinterface

// File: rtl/imem_word_packer.sv
// Packs accepted payload bytes little-endian into 32-bit words and flags each
// completed word one cycle after its fourth byte.
module imem_word_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic [7:0]  i_byte,
   output logic        o_last,
   output logic [31:0] o_word,
   output logic        o_word_done
);

   logic [1:0]  r_bidx;
   logic [31:0] r_shift;
   logic        r_word_done;

   assign o_last      = (r_bidx == 2'd3);
   assign o_word      = r_shift;
   assign o_word_done = r_word_done;

   // Shifting in from the top leaves the first byte of a group in [7:0].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bidx      <= 2'd0;
         r_shift     <= 32'd0;
         r_word_done <= 1'b0;
      end else begin
         r_word_done <= i_en && (r_bidx == 2'd3);
         if (i_clr) begin
            r_bidx <= 2'd0;
         end else if (i_en) begin
            r_shift <= {i_byte, r_shift[31:8]};
            r_bidx  <= r_bidx + 2'd1;
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: receives length, payload and XOR checksum, writes
// instruction memory word by word and releases the core on a good image.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_start,
   imem_loader_if.slave  bus,
   output logic          o_cpu_rst_n,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err
);

   logic [2:0]        r_state;
   len_t              r_len;
   len_t              r_wcnt;
   logic [ADDR_W-1:0] r_waddr;
   logic [7:0]        r_csum;

   logic        w_ready;
   logic        w_acc;
   logic        w_data_acc;
   logic        w_clr;
   logic        w_last_byte;
   logic [31:0] w_word;
   logic        w_word_done;
   len_t        w_len;

   assign w_ready = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                    (r_state == S_DATA)   || (r_state == S_CSUM);
   assign w_acc      = bus.byte_valid && w_ready;
   assign w_data_acc = w_acc && (r_state == S_DATA);
   assign w_clr      = i_start && !w_ready;
   assign w_len      = {bus.byte_data, r_len[7:0]};

   imem_word_packer u_packer (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr       (w_clr),
      .i_en        (w_data_acc),
      .i_byte      (bus.byte_data),
      .o_last      (w_last_byte),
      .o_word      (w_word),
      .o_word_done (w_word_done)
   );

   assign bus.byte_ready = w_ready;
   assign bus.we         = w_word_done;
   assign bus.waddr      = r_waddr;
   assign bus.wdata      = w_word;
   assign o_busy         = w_ready;
   assign o_done         = (r_state == S_DONE);
   assign o_err          = (r_state == S_ERR);
   assign o_cpu_rst_n    = (r_state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_len   <= '0;
         r_wcnt  <= '0;
         r_waddr <= '0;
         r_csum  <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (i_start) begin
                  r_state <= S_LEN_LO;
                  r_len   <= '0;
                  r_wcnt  <= '0;
                  r_waddr <= '0;
                  r_csum  <= 8'd0;
               end
            end
            S_LEN_LO: begin
               if (w_acc) begin
                  r_len[7:0] <= bus.byte_data;
                  r_state    <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (w_acc) begin
                  r_len   <= w_len;
                  r_state <= len_ok(w_len, DEPTH) ? S_DATA : S_ERR;
               end
            end
            S_DATA: begin
               if (w_acc) begin
                  r_csum <= r_csum ^ bus.byte_data;
                  // Latch the index now so it is stable during the write strobe.
                  if (w_last_byte) begin
                     r_waddr <= r_wcnt[ADDR_W-1:0];
                     r_wcnt  <= r_wcnt + len_t'(1);
                     if (r_wcnt == r_len - len_t'(1))
                        r_state <= S_CSUM;
                  end
               end
            end
            S_CSUM: begin
               if (w_acc)
                  r_state <= (bus.byte_data == r_csum) ? S_DONE : S_ERR;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader against a frame-level model.
module tb_imem_loader;

   localparam int DEPTH = 64;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic i_start = 1'b0;
   logic o_cpu_rst_n, o_busy, o_done, o_err;

   int checks = 0;
   int errors = 0;

   imem_loader_if #(.ADDR_W(6)) bus ();

   imem_loader #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (i_start),
      .bus         (bus),
      .o_cpu_rst_n (o_cpu_rst_n),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err)
   );

   always #5 clk = ~clk;

   // Observed writes, sampled mid-cycle.
   int          got_addr[$];
   logic [31:0] got_data[$];
   logic        prev_we = 1'b0;

   always @(negedge clk) begin
      if (bus.we) begin
         got_addr.push_back(int'(bus.waddr));
         got_data.push_back(bus.wdata);
         checks++;
         if (prev_we) begin
            errors++;
            $display("FAIL we_width: we high on consecutive cycles at waddr %0d", bus.waddr);
         end
      end
      prev_we <= bus.we;
   end

   // Frame-level reference model.
   int          exp_addr[$];
   logic [31:0] exp_data[$];
   logic        exp_done, exp_err;

   task automatic build_expect(input bq_t b);
      int n;
      logic [7:0] x;
      exp_addr.delete();
      exp_data.delete();
      n = int'(b[0]) + 256 * int'(b[1]);
      if (n == 0 || n > DEPTH) begin
         exp_done = 1'b0;
         exp_err  = 1'b1;
         return;
      end
      x = 8'd0;
      for (int i = 0; i < n; i++) begin
         exp_addr.push_back(i);
         exp_data.push_back({b[5+4*i], b[4+4*i], b[3+4*i], b[2+4*i]});
      end
      for (int i = 2; i < 2 + 4*n; i++) x = x ^ b[i];
      exp_done = (b[2+4*n] == x);
      exp_err  = !exp_done;
   endtask

   task automatic make_frame(input int n, input bit bad, output bq_t f);
      logic [7:0] x;
      f.delete();
      f.push_back(n[7:0]);
      f.push_back(n[15:8]);
      x = 8'd0;
      for (int i = 0; i < 4*n; i++) begin
         logic [7:0] v;
         v = 8'($urandom);
         x = x ^ v;
         f.push_back(v);
      end
      f.push_back(bad ? (x ^ 8'(1 + $urandom_range(254))) : x);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   // Presents bytes with random valid gaps; optionally pulses start once
   // after start_at bytes have been accepted. Returns at a negedge.
   task automatic send_bytes(input bq_t b, input int cnt, input int pct,
                             input int start_at, output bit timeout);
      int idx = 0;
      int cyc = 0;
      bit injected = 0;
      logic r;
      bit v;
      timeout = 0;
      while (idx < cnt) begin
         if (cyc > 4000) begin
            timeout = 1;
            break;
         end
         @(negedge clk);
         i_start = 1'b0;
         r = bus.byte_ready;
         if (!injected && idx == start_at) begin
            injected = 1;
            i_start = 1'b1;
            v = 0;
         end else begin
            v = ($urandom_range(99) < pct);
         end
         bus.byte_valid = v;
         bus.byte_data  = v ? b[idx] : 8'($urandom);
         @(posedge clk);
         if (v && r) idx++;
         cyc++;
      end
      @(negedge clk);
      i_start = 1'b0;
      bus.byte_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'hA5;
      i_start = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.byte_ready); end
      checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.we); end
      checks++; if (bus.waddr !== 6'd0) begin errors++; $display("FAIL reset_waddr: got %0d want 0", bus.waddr); end
      checks++; if (bus.wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.wdata); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      checks++; if (o_done !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL reset_status: done %b err %b want 0 0", o_done, o_err); end
      checks++; if (o_cpu_rst_n !== 1'b0) begin errors++; $display("FAIL reset_cpu: got %b want 0", o_cpu_rst_n); end
      bus.byte_valid = 1'b0;
      i_start = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", o_busy); end
   endtask

   task automatic test_spec_frame();
      bq_t f;
      bit to;
      f = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00, 8'h10};
      got_addr.delete(); got_data.delete();
      pulse_start();
      checks++; if (o_cpu_rst_n !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL spec_start: cpu %b busy %b want 0 1", o_cpu_rst_n, o_busy); end
      send_bytes(f, f.size(), 100, -1, to);
      checks++; if (to) begin errors++; $display("FAIL spec_timeout: bytes not accepted in budget"); end
      checks++;
      if (got_addr.size() != 2 || got_addr[0] != 0 || got_data[0] !== 32'h00500113 ||
          got_addr[1] != 1 || got_data[1] !== 32'h00C00193) begin
         errors++;
         $display("FAIL spec_writes: got %0d writes want 2 (0:00500113 1:00c00193)", got_addr.size());
      end
      checks++; if (o_done !== 1'b1 || o_err !== 1'b0 || o_cpu_rst_n !== 1'b1) begin
         errors++; $display("FAIL spec_status: done %b err %b cpu %b want 1 0 1", o_done, o_err, o_cpu_rst_n); end
      // Bad checksum on the same frame.
      f[10] = 8'h11;
      got_addr.delete(); got_data.delete();
      pulse_start();
      send_bytes(f, f.size(), 100, -1, to);
      checks++; if (got_addr.size() != 2 || got_data[1] !== 32'h00C00193) begin
         errors++; $display("FAIL badcsum_writes: got %0d writes want 2", got_addr.size()); end
      checks++; if (o_done !== 1'b0 || o_err !== 1'b1 || o_cpu_rst_n !== 1'b0) begin
         errors++; $display("FAIL badcsum_status: done %b err %b cpu %b want 0 1 0", o_done, o_err, o_cpu_rst_n); end
   endtask

   task automatic test_bad_len();
      bq_t f;
      bit to;
      logic [7:0] lens[2];
      lens[0] = 8'h00;
      lens[1] = 8'h41;
      for (int k = 0; k < 2; k++) begin
         f.delete();
         f.push_back(lens[k]);
         f.push_back(8'h00);
         for (int i = 0; i < 8; i++) f.push_back(8'($urandom));
         build_expect(f);
         got_addr.delete(); got_data.delete();
         pulse_start();
         send_bytes(f, 2, 70, -1, to);
         // Further bytes must be refused once in ERR.
         bus.byte_valid = 1'b1;
         repeat (6) @(negedge clk);
         bus.byte_valid = 1'b0;
         checks++; if (got_addr.size() != 0) begin errors++; $display("FAIL badlen_we: len %h got %0d writes want 0", lens[k], got_addr.size()); end
         checks++; if (o_err !== exp_err || o_done !== exp_done || o_busy !== 1'b0) begin
            errors++; $display("FAIL badlen_status: len %h err %b done %b busy %b want %b %b 0", lens[k], o_err, o_done, o_busy, exp_err, exp_done); end
      end
   endtask

   task automatic test_random_frames();
      bq_t f;
      bit to;
      int ns[6];
      bit bads[6];
      ns = '{1, 3, 64, 5, 7, 64};
      bads = '{0, 1, 0, 0, 1, 1};
      for (int k = 0; k < 6; k++) begin
         make_frame(ns[k], bads[k], f);
         build_expect(f);
         got_addr.delete(); got_data.delete();
         pulse_start();
         send_bytes(f, f.size(), 30 + 10 * k, -1, to);
         checks++; if (to) begin errors++; $display("FAIL rand_timeout: frame %0d", k); end
         checks++; if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL rand_count: frame %0d got %0d writes want %0d", k, got_addr.size(), exp_addr.size());
         end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
               checks++;
               if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) begin
                  errors++;
                  $display("FAIL rand_write: frame %0d #%0d got %0d:%h want %0d:%h", k, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
               end
            end
         end
         checks++; if (o_done !== exp_done || o_err !== exp_err || o_cpu_rst_n !== exp_done || o_busy !== 1'b0) begin
            errors++; $display("FAIL rand_status: frame %0d done %b err %b cpu %b busy %b want %b %b %b 0", k, o_done, o_err, o_cpu_rst_n, o_busy, exp_done, exp_err, exp_done); end
      end
   endtask

   task automatic test_reset_midload();
      bq_t f;
      bit to;
      make_frame(3, 0, f);
      got_addr.delete(); got_data.delete();
      pulse_start();
      send_bytes(f, 8, 60, -1, to);
      rst_n = 1'b0;
      #1;
      checks++; if (o_busy !== 1'b0 || o_cpu_rst_n !== 1'b0 || bus.byte_ready !== 1'b0) begin
         errors++; $display("FAIL midrst_state: busy %b cpu %b ready %b want 0 0 0", o_busy, o_cpu_rst_n, bus.byte_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      bus.byte_valid = 1'b1;
      bus.byte_data = 8'h5A;
      repeat (10) @(negedge clk);
      bus.byte_valid = 1'b0;
      checks++; if (got_addr.size() != 1) begin errors++; $display("FAIL midrst_we: got %0d writes want 1", got_addr.size()); end
      checks++; if (o_cpu_rst_n !== 1'b0 || o_done !== 1'b0) begin errors++; $display("FAIL midrst_hold: cpu %b done %b want 0 0", o_cpu_rst_n, o_done); end
      build_expect(f);
      got_addr.delete(); got_data.delete();
      pulse_start();
      send_bytes(f, f.size(), 80, -1, to);
      checks++; if (got_addr.size() != 3 || got_data[2] !== exp_data[2]) begin
         errors++; $display("FAIL midrst_reload: got %0d writes want 3", got_addr.size()); end
      checks++; if (o_done !== 1'b1 || o_cpu_rst_n !== 1'b1) begin errors++; $display("FAIL midrst_done: done %b cpu %b want 1 1", o_done, o_cpu_rst_n); end
   endtask

   task automatic test_start_handling();
      bq_t f;
      bit to;
      make_frame(2, 0, f);
      build_expect(f);
      got_addr.delete(); got_data.delete();
      pulse_start();
      // Start arrives in DATA after 5 accepted bytes and must be ignored.
      send_bytes(f, f.size(), 75, 5, to);
      checks++; if (got_addr.size() != 2 || got_data[0] !== exp_data[0] || got_data[1] !== exp_data[1]) begin
         errors++; $display("FAIL start_data_writes: got %0d writes want 2", got_addr.size()); end
      checks++; if (o_done !== 1'b1 || o_cpu_rst_n !== 1'b1) begin errors++; $display("FAIL start_data_done: done %b cpu %b want 1 1", o_done, o_cpu_rst_n); end
      pulse_start();
      checks++; if (o_cpu_rst_n !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1) begin
         errors++; $display("FAIL restart: cpu %b done %b busy %b want 0 0 1", o_cpu_rst_n, o_done, o_busy); end
      make_frame(4, 0, f);
      build_expect(f);
      got_addr.delete(); got_data.delete();
      send_bytes(f, f.size(), 90, -1, to);
      checks++; if (got_addr.size() != 4 || got_data[3] !== exp_data[3] || o_done !== 1'b1) begin
         errors++; $display("FAIL restart_load: writes %0d done %b want 4 1", got_addr.size(), o_done); end
   endtask

   initial begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'd0;
      test_reset();
      test_spec_frame();
      test_bad_len();
      test_random_frames();
      test_reset_midload();
      test_start_handling();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
